// File: rtl/alu_pkg.sv
// Shared definitions for the operand loader and the downstream ALU stage.
// Holds the default operand width, the loader FSM state enum and the
// board LED encodings for each state.
package alu_pkg;

  localparam int unsigned OPERAND_W = 6;
  localparam int unsigned STATE_W   = 2;

  // LED encodings double as the state encodings.
  localparam logic [STATE_W-1:0] LED_LOAD_A = 2'b00;
  localparam logic [STATE_W-1:0] LED_LOAD_B = 2'b01;
  localparam logic [STATE_W-1:0] LED_READY  = 2'b10;

  // 2'b11 is intentionally left unnamed; the FSM recovers from it.
  typedef enum logic [STATE_W-1:0] {
    ST_LOAD_A = LED_LOAD_A,
    ST_LOAD_B = LED_LOAD_B,
    ST_READY  = LED_READY
  } state_e;

  // Map a state to the pattern shown on the board LEDs.
  function automatic logic [STATE_W-1:0] state_led_f(input state_e s);
    return STATE_W'(s);
  endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Board-side bundle of the operand loader.
//   sw             : switch value (async to clk)
//   btn_load       : raw push-button (async to clk)
//   op_a / op_b    : latched operands
//   operands_valid : a complete pair is held
//   state_led      : loader state for the LEDs
// master drives sw/btn_load (board / bench); slave is the loader.
interface operand_loader_if import alu_pkg::*; #(
  parameter int unsigned W = OPERAND_W
) ();

  logic [W-1:0]       sw;
  logic               btn_load;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic               operands_valid;
  logic [STATE_W-1:0] state_led;

  modport master (
    output sw,
    output btn_load,
    input  op_a,
    input  op_b,
    input  operands_valid,
    input  state_led
  );

  modport slave (
    input  sw,
    input  btn_load,
    output op_a,
    output op_b,
    output operands_valid,
    output state_led
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, saturating stability
// counter debouncer and press-edge detector.
//   clk, reset : system clock, synchronous active-high reset
//   btn_raw    : raw bouncing button (async to clk)
//   btn_pulse  : registered one-cycle pulse per accepted press
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int unsigned   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             pulse_q, pulse_d;

  // Synchronize, count disagreement, flip level and flag a press.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      // This cycle completes the required run of disagreeing cycles.
      level_d = ~level_q;
      cnt_d   = '0;
      pulse_d = ~level_q;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_pulse = pulse_q;

endmodule

// File: rtl/operand_loader.sv
// Loads two operands from the board switches, one per debounced press
// of the load button, alternating A then B; after a full pair a further
// press starts a new pair by reloading A.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : sw/btn_load in, op_a/op_b/operands_valid/state_led out
module operand_loader import alu_pkg::*; #(
  parameter int unsigned W               = OPERAND_W,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  operand_loader_if.slave  bus
);

  logic         load_pulse;

  logic [W-1:0] sw_s1_q, sw_s1_d;
  logic [W-1:0] sw_s2_q, sw_s2_d;
  state_e       state_q, state_d;
  logic [W-1:0] op_a_q,  op_a_d;
  logic [W-1:0] op_b_q,  op_b_d;
  logic         valid_q, valid_d;

  // Button conditioning.
  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (bus.btn_load),
    .btn_pulse (load_pulse)
  );

  // Switch synchronizer.
  always_comb begin
    sw_s1_d = bus.sw;
    sw_s2_d = sw_s1_q;
  end

  // Loader FSM next state and operand updates.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;

    case (state_q)
      ST_LOAD_A: begin
        if (load_pulse) begin
          op_a_d  = sw_s2_q;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (load_pulse) begin
          op_b_d  = sw_s2_q;
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (load_pulse) begin
          op_a_d  = sw_s2_q;
          state_d = ST_LOAD_B;
        end
      end
      default: begin
        state_d = ST_LOAD_A;
      end
    endcase

    // Kept as its own flop so it tracks the state register exactly.
    valid_d = (state_d == ST_READY);
  end

  // State registers; reset wins over a coincident load pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      state_q <= ST_LOAD_A;
      op_a_q  <= '0;
      op_b_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      valid_q <= valid_d;
    end
  end

  assign bus.op_a           = op_a_q;
  assign bus.op_b           = op_b_q;
  assign bus.operands_valid = valid_q;
  assign bus.state_led      = state_led_f(state_q);

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a short debounce period.
module tb_operand_loader;
  import alu_pkg::*;

  localparam int unsigned W  = 6;
  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  operand_loader_if #(.W(W)) bus ();

  operand_loader #(
    .W               (W),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Counts changes of state_led between consecutive pre-edge samples.
  int         trans    = 0;
  logic [1:0] last_led = 2'b00;
  always @(posedge clk) begin
    if (bus.state_led !== last_led) trans <= trans + 1;
    last_led <= bus.state_led;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clean press: held long enough to debounce, then released and settled.
  task automatic press();
    bus.btn_load = 1'b1;
    tick(8);
    bus.btn_load = 1'b0;
    tick(8);
  endtask

  int         t0;
  logic [4:0] bounce;

  initial begin
    reset        = 1'b1;
    bus.btn_load = 1'b1;
    bus.sw       = 6'h00;
    tick(3);
    reset = 1'b0;

    // Reset held with button pressed.
    chk("rst_op_a",  32'(bus.op_a), 32'h0);
    chk("rst_op_b",  32'(bus.op_b), 32'h0);
    chk("rst_valid", 32'(bus.operands_valid), 32'h0);
    chk("rst_led",   32'(bus.state_led), 32'h0);
    tick(6);
    chk("rst_no_early_load", 32'(bus.state_led), 32'h0);
    tick(1);
    chk("rst_late_load", 32'(bus.state_led), 32'h1);
    bus.btn_load = 1'b0;
    tick(8);

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Load A then B.
    bus.sw = 6'h2A;
    tick(3);
    press();
    chk("a_led",   32'(bus.state_led), 32'h1);
    chk("a_op_a",  32'(bus.op_a), 32'h2A);
    chk("a_valid", 32'(bus.operands_valid), 32'h0);
    bus.sw = 6'h15;
    tick(3);
    press();
    chk("b_op_a",  32'(bus.op_a), 32'h2A);
    chk("b_op_b",  32'(bus.op_b), 32'h15);
    chk("b_valid", 32'(bus.operands_valid), 32'h1);
    chk("b_led",   32'(bus.state_led), 32'h2);

    // Press in READY reloads A.
    bus.sw = 6'h3F;
    tick(3);
    press();
    chk("rdy_op_a",  32'(bus.op_a), 32'h3F);
    chk("rdy_op_b",  32'(bus.op_b), 32'h15);
    chk("rdy_valid", 32'(bus.operands_valid), 32'h0);
    chk("rdy_led",   32'(bus.state_led), 32'h1);

    // Bouncing press.
    bus.sw = 6'h0C;
    tick(3);
    t0     = trans;
    bounce = 5'b10110;
    for (int i = 4; i >= 0; i--) begin
      bus.btn_load = bounce[i];
      tick(1);
    end
    chk("bnc_no_load", 32'(bus.state_led), 32'h1);
    bus.btn_load = 1'b1;
    tick(10);
    bus.btn_load = 1'b0;
    tick(8);
    chk("bnc_one_trans", 32'(trans - t0), 32'h1);
    chk("bnc_op_b",      32'(bus.op_b), 32'h0C);
    chk("bnc_led",       32'(bus.state_led), 32'h2);
    chk("bnc_valid",     32'(bus.operands_valid), 32'h1);

    // Long hold.
    bus.sw = 6'h07;
    tick(3);
    t0 = trans;
    bus.btn_load = 1'b1;
    tick(100);
    bus.btn_load = 1'b0;
    tick(8);
    chk("hold_one_trans", 32'(trans - t0), 32'h1);
    chk("hold_led",       32'(bus.state_led), 32'h1);
    chk("hold_op_a",      32'(bus.op_a), 32'h07);
    chk("hold_op_b",      32'(bus.op_b), 32'h0C);

    // Reset coincident with the LOAD_B pulse.
    bus.sw = 6'h11;
    tick(3);
    bus.btn_load = 1'b1;
    tick(6);
    chk("coin_pre_led", 32'(bus.state_led), 32'h1);
    reset = 1'b1;
    tick(1);
    chk("coin_op_b",  32'(bus.op_b), 32'h0);
    chk("coin_op_a",  32'(bus.op_a), 32'h0);
    chk("coin_led",   32'(bus.state_led), 32'h0);
    chk("coin_valid", 32'(bus.operands_valid), 32'h0);
    tick(1);
    reset = 1'b0;

    // Button still held: needs a full debounce period again.
    tick(6);
    chk("post_rst_no_early", 32'(bus.state_led), 32'h0);
    tick(1);
    chk("post_rst_led",  32'(bus.state_led), 32'h1);
    chk("post_rst_op_a", 32'(bus.op_a), 32'h11);
    bus.btn_load = 1'b0;
    tick(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter W, default 6: operand width in bits.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sw  input  W  operand value from the board switches; asynchronous to clk.
REQ-006 btn_load  input  1  raw, bouncing push-button; asynchronous to clk.
REQ-007 op_a  output  W  latched operand A; feeds the downstream bitwise/ALU stage input a.
REQ-008 op_b  output  W  latched operand B; feeds the downstream stage input b.
REQ-009 operands_valid  output  1  high while op_a and op_b both hold a completed load pair.
REQ-010 state_led  output  2  current FSM state encoding, for board LEDs.

Function
REQ-011 btn_load SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement SHALL clear the stability counter to 0.
REQ-013 The stability counter SHALL saturate, not wrap, and SHALL be sized ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-014 A load pulse of exactly one cycle SHALL be generated on the cycle after the debounced level goes 0->1; release (1->0) SHALL generate no pulse.
REQ-015 A press held indefinitely SHALL yield exactly one load pulse.
REQ-016 FSM states: LOAD_A (state_led=00), LOAD_B (01), READY (10); encoding 11 unused and SHALL recover to LOAD_A on the next cycle.
REQ-017 LOAD_A + pulse: op_a <= synchronized sw; next state LOAD_B.
REQ-018 LOAD_B + pulse: op_b <= synchronized sw; next state READY; operands_valid rises on that same clock edge.
REQ-019 READY + pulse: op_a <= synchronized sw; op_b holds; operands_valid falls on that same edge; next state LOAD_B.
REQ-020 Without a pulse, state, op_a, op_b and operands_valid SHALL hold.
REQ-021 sw SHALL be captured through a 2-flop synchronizer; the value loaded is the synchronized sw at the edge where the pulse is high.
REQ-022 All outputs SHALL be registered; no combinational path from sw or btn_load to any output.
REQ-023 operands_valid SHALL be 1 exactly when state is READY.

Reset
REQ-024 reset SHALL take priority over every other event, including a coincident load pulse.
REQ-025 Reset values: op_a=0, op_b=0, operands_valid=0, state_led=00 (LOAD_A), stability counter=0, debounced level=0, synchronizer flops=0.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count; a button still held after reset SHALL produce a pulse only after a full DEBOUNCE_CYCLES period.

Structure
REQ-027 The FSM state enumeration and the state_led encodings SHALL reside in a shared package alu_pkg, alongside the default operand width constant.
REQ-028 Synchronizer, debounce counter and edge detector SHALL form one sub-module, btn_debounce (ports clk, reset, btn_raw, btn_pulse), reusable for other board buttons.
REQ-029 operand_loader SHALL instantiate btn_debounce once and contain the FSM and operand registers.

Verification (run with DEBOUNCE_CYCLES=4)
REQ-030 Reset with btn_load held high -> after release of reset, all outputs 0 and state_led=00; one pulse no earlier than 2+4 cycles later.
REQ-031 sw=6'h2A, clean press; then sw=6'h15, clean press -> op_a=6'h2A, op_b=6'h15, operands_valid=1, state_led=10.
REQ-032 Bouncing press (1,0,1,1,0 then stable 1 for 10 cycles) -> exactly one load pulse; no load occurs during the bounce.
REQ-033 In READY, sw=6'h3F, press -> op_a=6'h3F, op_b unchanged, operands_valid=0, state_led=01.
REQ-034 Button held for 100 cycles -> exactly one state transition.
REQ-035 reset asserted on the same cycle as the LOAD_B pulse -> op_b stays 0, state_led=00, operands_valid=0.
